// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: fetch FSM encoding, predictor constants and counter update helper
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {BOOT, FETCH, WAIT} fetch_state_t;

    localparam logic [1:0]  CTR_RESET   = 2'b01;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        return taken ? ((c == 2'b11) ? c : c + 2'b01) : ((c == 2'b00) ? c : c - 2'b01);
    endfunction

endpackage

// File: rtl/bimodal_pht.sv
// bimodal_pht: table of 2-bit saturating direction counters, read combinationally, updated at the edge
module bimodal_pht
    import pc_fetch_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_ctr,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_idx,
    input  logic          taken
);

    logic [1:0] ctr [ENTRIES];

    // the read sees the registered value, so a same-entry update lands after the lookup
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RESET;
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], taken);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC generation with BTB/bimodal prediction, memory-wait FSM and mispredict redirect
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          PHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic        flush,
    output logic [31:0] mispredict_cnt
);

    localparam int IW = $clog2(PHT_ENTRIES);

    fetch_state_t state, state_nx;
    logic [1:0]   rd_ctr;
    logic [31:0]  pc_nx;
    logic         pred_taken, ex_upd, mispredict, fetch_ok;

    assign ex_upd     = ex_valid & ex_is_branch;
    assign mispredict = ex_upd & (ex_taken != ex_pred_taken);
    assign flush      = mispredict;
    assign pred_taken = btb_hit & rd_ctr[1];
    assign imem_req   = state != BOOT;
    assign fetch_ok   = imem_ready & (state != BOOT);

    bimodal_pht #(.ENTRIES(PHT_ENTRIES)) u_pht (
        .clk     (clk),
        .rstn    (rstn),
        .rd_idx  (pc[IW+1:2]),
        .rd_ctr  (rd_ctr),
        .upd_en  (ex_upd),
        .upd_idx (ex_pc[IW+1:2]),
        .taken   (ex_taken)
    );

    // an outstanding fetch (ready low) holds pc exactly like a hazard stall
    always_comb begin
        pc_nx    = mispredict ? (ex_taken ? ex_target : ex_pc + INSTR_BYTES)
                 : (stall || !fetch_ok) ? pc
                 : pred_taken ? btb_target : pc + INSTR_BYTES;
        state_nx = (state == BOOT) ? FETCH
                 : (state == FETCH) ? ((!imem_ready && !mispredict) ? WAIT : FETCH)
                 : (imem_ready ? FETCH : WAIT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            mispredict_cnt <= '0;
        end else begin
            state          <= state_nx;
            pc             <= pc_nx;
            mispredict_cnt <= mispredict_cnt + {31'd0, mispredict};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_valid      <= 1'b0;
            if_pc         <= '0;
            if_pred_taken <= 1'b0;
        end else if (mispredict) begin
            if_valid <= 1'b0;
        end else if (!stall) begin
            if_valid <= fetch_ok;
            if (fetch_ok) begin
                if_pc         <= pc;
                if_pred_taken <= pred_taken;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table-driven vectors with an expectation queue, plus reset-in-WAIT and counter-wrap sequences
module tb_pc_fetch_unit;

    logic        clk = 1'b0, rstn = 1'b0, stall = 1'b0, imem_ready = 1'b1, btb_hit = 1'b0;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
    logic [31:0] btb_target = '0, ex_target = '0, ex_pc = '0;
    logic [31:0] pc, if_pc, mispredict_cnt;
    logic        imem_req, if_valid, if_pred_taken, flush;

    pc_fetch_unit dut (
        .clk(clk), .rstn(rstn), .stall(stall), .imem_ready(imem_ready),
        .btb_hit(btb_hit), .btb_target(btb_target), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .pc(pc), .imem_req(imem_req),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .flush(flush), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, rdy, hit;
        logic [31:0] tgt;
        logic        exv, ext;
        logic [31:0] ex_tgt, expc;
        logic        expred;
        logic [31:0] pc;
        logic        req, fl;
        logic [31:0] npc;
        logic        ifv;
        logic [31:0] ifpc;
        logic        ifpr;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] npc;
        logic        ifv;
        logic [31:0] ifpc;
        logic        ifpr;
        logic [31:0] cnt;
    } exp_t;

    localparam int NV = 31;
    vec_t vt [NV];
    exp_t sb [$];
    exp_t e;
    int   n_vec = 0, n_fail = 0;

    function automatic vec_t nv(input logic s, input logic r, input logic h, input logic [31:0] t,
                                input logic [31:0] p, input logic q, input logic [31:0] np,
                                input logic iv, input logic [31:0] ip, input logic ipr, input logic [31:0] c);
        vec_t v;
        v = '{stall: s, rdy: r, hit: h, tgt: t, exv: 1'b0, ext: 1'b0, ex_tgt: 32'd0, expc: 32'd0,
              expred: 1'b0, pc: p, req: q, fl: 1'b0, npc: np, ifv: iv, ifpc: ip, ifpr: ipr, cnt: c};
        return v;
    endfunction

    function automatic vec_t ex(input vec_t b, input logic tk, input logic [31:0] tg,
                                input logic [31:0] xp, input logic pr, input logic fl);
        vec_t v;
        v = b;
        v.exv = 1'b1; v.ext = tk; v.ex_tgt = tg; v.expc = xp; v.expred = pr; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; imem_ready = v.rdy; btb_hit = v.hit; btb_target = v.tgt;
        ex_valid = v.exv; ex_is_branch = v.exv; ex_taken = v.ext; ex_target = v.ex_tgt;
        ex_pc = v.expc; ex_pred_taken = v.expred;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = nv(0,1,0,0,        32'h0,1'b0,32'h0,   0,32'h0,  0,0);
        vt[1]  = nv(0,1,0,0,        32'h0,1'b1,32'h4,   1,32'h0,  0,0);
        vt[2]  = nv(0,1,0,0,        32'h4,1'b1,32'h8,   1,32'h4,  0,0);
        vt[3]  = nv(0,0,0,0,        32'h8,1'b1,32'h8,   0,32'h0,  0,0);
        vt[4]  = vt[3];
        vt[5]  = vt[3];
        vt[6]  = nv(0,1,0,0,        32'h8,1'b1,32'hC,   1,32'h8,  0,0);
        vt[7]  = nv(0,1,0,0,        32'hC,1'b1,32'h10,  1,32'hC,  0,0);
        vt[8]  = nv(0,1,1,32'h80,   32'h10,1'b1,32'h14, 1,32'h10, 0,0);
        vt[9]  = ex(nv(0,1,0,0,     32'h14,1'b1,32'h18, 1,32'h14, 0,0), 1,32'h0,32'h10,1,0);
        vt[10] = ex(nv(0,1,0,0,     32'h18,1'b1,32'h1C, 1,32'h18, 0,0), 1,32'h0,32'h10,1,0);
        vt[11] = ex(nv(0,1,0,0,     32'h1C,1'b1,32'h10, 0,32'h0,  0,1), 1,32'h10,32'h60,0,1);
        vt[12] = nv(0,1,1,32'h80,   32'h10,1'b1,32'h80, 1,32'h10, 1,1);
        vt[13] = ex(nv(1,1,0,0,     32'h80,1'b1,32'h200,0,32'h0,  0,2), 1,32'h200,32'h70,0,1);
        vt[14] = nv(0,1,0,0,        32'h200,1'b1,32'h204,1,32'h200,0,2);
        vt[15] = ex(nv(0,1,0,0,     32'h204,1'b1,32'h44,0,32'h0,  0,3), 0,32'h0,32'h40,1,1);
        vt[16] = ex(nv(0,1,0,0,     32'h44,1'b1,32'h48, 1,32'h44, 0,3), 0,32'h0,32'h40,0,0);
        vt[17] = ex(nv(0,1,0,0,     32'h48,1'b1,32'h4C, 1,32'h48, 0,3), 0,32'h0,32'h40,0,0);
        vt[18] = ex(nv(0,1,0,0,     32'h4C,1'b1,32'h50, 1,32'h4C, 0,3), 0,32'h0,32'h40,0,0);
        vt[19] = ex(nv(0,1,0,0,     32'h50,1'b1,32'h54, 1,32'h50, 0,3), 1,32'h0,32'h40,1,0);
        vt[20] = ex(nv(0,1,0,0,     32'h54,1'b1,32'h100,0,32'h0,  0,4), 1,32'h100,32'h64,0,1);
        vt[21] = nv(0,1,1,32'h300,  32'h100,1'b1,32'h104,1,32'h100,0,4);
        vt[22] = nv(1,1,0,0,        32'h104,1'b1,32'h104,1,32'h100,0,4);
        vt[23] = ex(nv(0,1,0,0,     32'h104,1'b1,32'h120,0,32'h0, 0,5), 1,32'h120,32'h6C,0,1);
        vt[24] = ex(nv(0,1,1,32'h400,32'h120,1'b1,32'h400,1,32'h120,1,5), 0,32'h0,32'h60,0,0);
        vt[25] = ex(nv(0,1,0,0,     32'h400,1'b1,32'h0, 0,32'h0,  0,6), 0,32'h0,32'hFFFF_FFFC,1,1);
        vt[26] = nv(0,1,0,0,        32'h0,1'b1,32'h4,   1,32'h0,  0,6);
        vt[27] = nv(0,0,0,0,        32'h4,1'b1,32'h4,   0,32'h0,  0,6);
        vt[28] = ex(nv(0,0,0,0,     32'h4,1'b1,32'h600, 0,32'h0,  0,7), 1,32'h600,32'h74,0,1);
        vt[29] = nv(0,0,0,0,        32'h600,1'b1,32'h600,0,32'h0, 0,7);
        vt[30] = nv(0,1,0,0,        32'h600,1'b1,32'h604,1,32'h600,0,7);

        @(posedge clk); #1;
        chk("rst_pc", 0, pc, 32'h0);
        chk("rst_req", 0, 32'(imem_req), 32'h0);
        chk("rst_ifv", 0, 32'(if_valid), 32'h0);
        chk("rst_ifpc", 0, if_pc, 32'h0);
        chk("rst_ifpr", 0, 32'(if_pred_taken), 32'h0);
        chk("rst_cnt", 0, mispredict_cnt, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            #1;
            chk("pc", i, pc, vt[i].pc);
            chk("imem_req", i, 32'(imem_req), 32'(vt[i].req));
            chk("flush", i, 32'(flush), 32'(vt[i].fl));
            sb.push_back('{idx: i, npc: vt[i].npc, ifv: vt[i].ifv, ifpc: vt[i].ifpc,
                           ifpr: vt[i].ifpr, cnt: vt[i].cnt});
            @(posedge clk); #1;
            e = sb.pop_front();
            chk("next_pc", e.idx, pc, e.npc);
            chk("if_valid", e.idx, 32'(if_valid), 32'(e.ifv));
            chk("mp_cnt", e.idx, mispredict_cnt, e.cnt);
            if (e.ifv) begin
                chk("if_pc", e.idx, if_pc, e.ifpc);
                chk("if_pred", e.idx, 32'(if_pred_taken), 32'(e.ifpr));
            end
        end

        imem_ready = 1'b0;
        @(posedge clk); #1;
        chk("wait_pc", 100, pc, 32'h604);
        chk("wait_req", 100, 32'(imem_req), 32'h1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_pc", 101, pc, 32'h0);
        chk("async_rst_req", 101, 32'(imem_req), 32'h0);
        chk("async_rst_cnt", 101, mispredict_cnt, 32'h0);
        chk("async_rst_ifv", 101, 32'(if_valid), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("boot_req", 102, 32'(imem_req), 32'h0);
        @(posedge clk); #1;
        chk("boot_exit_req", 103, 32'(imem_req), 32'h1);
        chk("boot_exit_pc", 103, pc, 32'h0);

        force dut.mispredict_cnt = 32'hFFFF_FFFF;
        #1 release dut.mispredict_cnt;
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        ex_target = 32'h700; ex_pc = 32'h78;
        #1;
        chk("wrap_flush", 104, 32'(flush), 32'h1);
        chk("wrap_preload", 104, mispredict_cnt, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap_cnt", 105, mispredict_cnt, 32'h0);
        chk("wrap_pc", 105, pc, 32'h700);
        ex_valid = 1'b0; ex_is_branch = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have parameter PHT_ENTRIES, default 16, which sets the number of 2-bit direction counters (power of 2).
REQ-003 SHALL have ports:
  - clk  in  1  clock
  - rstn  in  1  reset, asynchronous, active-low
  - stall  in  1  hazard-unit hold of fetch and IF/ID
  - imem_ready  in  1  instruction memory accepted/returned this cycle
  - btb_hit  in  1  BTB lookup hit for pc
  - btb_target  in  32  BTB predicted target for pc
  - ex_valid  in  1  EXE stage holds a valid instruction
  - ex_is_branch  in  1  EXE instruction is a conditional branch
  - ex_taken  in  1  resolved direction
  - ex_target  in  32  resolved taken target
  - ex_pc  in  32  PC of the EXE instruction
  - ex_pred_taken  in  1  prediction carried down the pipe for the EXE instruction
  - pc  out  32  current fetch address (to BTB and imem)
  - imem_req  out  1  fetch request
  - if_valid  out  1  IF/ID contents valid
  - if_pc  out  32  PC of the IF/ID instruction
  - if_pred_taken  out  1  prediction for the IF/ID instruction
  - flush  out  1  kill IF/ID and ID/EXE this cycle
  - mispredict_cnt  out  32  count of mispredictions

Function
REQ-004 SHALL contain a PHT_ENTRIES x 2-bit counter table indexed by pc[log2(PHT_ENTRIES)+1:2].
REQ-005 SHALL predict taken iff btb_hit=1 and the indexed counter bit[1]=1; pred_taken is combinational on pc.
REQ-006 SHALL declare mispredict = ex_valid & ex_is_branch & (ex_taken != ex_pred_taken); target compare is not required because BTB targets are direct pc+imm.
REQ-007 SHALL drive flush=mispredict, combinationally, in the same cycle.
REQ-008 SHALL select next pc with priority: mispredict (ex_taken ? ex_target : ex_pc+4) > stall or WAIT state (hold) > pred_taken (btb_target) > pc+4; adds wrap modulo 2^32.
REQ-009 SHALL implement FSM states BOOT, FETCH, and WAIT.
  - BOOT: entered on reset; imem_req=0; goes to FETCH after one clock.
  - FETCH: imem_req=1; if imem_ready=0 and no mispredict, goes to WAIT holding pc.
  - WAIT: imem_req=1, pc held; returns to FETCH when imem_ready=1; on mispredict, loads the redirect pc and stays in WAIT if imem_ready=0.
REQ-010 SHALL, on a clock edge in FETCH or WAIT with imem_ready=1, stall=0, and mispredict=0, load if_valid=1, if_pc=pc, and if_pred_taken=pred_taken.
REQ-011 SHALL, on a clock edge with stall=1 and no mispredict, hold if_valid, if_pc, and if_pred_taken unchanged.
REQ-012 SHALL, on a clock edge with imem_ready=0, stall=0, and no mispredict, load if_valid=0.
REQ-013 SHALL, on a clock edge with mispredict=1, load if_valid=0 regardless of stall or imem_ready; mispredict overrides stall.
REQ-014 SHALL, when ex_valid & ex_is_branch, saturate-update the counter indexed by ex_pc: increment toward 2'b11 if taken, decrement toward 2'b00 if not.
REQ-015 SHALL resolve a same-cycle update and lookup of the same entry so that the lookup sees the pre-update value and the update commits at the edge.
REQ-016 SHALL increment mispredict_cnt by 1 at each clock edge where mispredict=1, wrapping from 32'hFFFF_FFFF to 0.

Reset
REQ-017 SHALL, on rstn low and asynchronously, set pc=RESET_PC, FSM=BOOT, if_valid=0, if_pc=0, if_pred_taken=0, mispredict_cnt=0, and all counters=2'b01 (weakly not-taken).
REQ-018 SHALL abandon any outstanding fetch when rstn is asserted mid-WAIT; imem_req=0 until BOOT exits.

Structure
REQ-019 SHALL take the FSM state encoding, counter reset value 2'b01, and instruction width constant 4 from the shared core package.
REQ-020 SHALL place the counter table in one sub-module, bimodal_pht, with ports: read index, read data, update enable, update index, and taken.

Verification
REQ-021 Reset and sequential fetch: release rstn, hold imem_ready=1, btb_hit=0 -> cycle 1 imem_req=0; then pc goes 0, 4, 8, 12; if_pc lags pc by one cycle.
REQ-022 BTB hit with weak counter: pc=0x10, btb_hit=1, btb_target=0x80, counter=01 -> next pc=0x14 and if_pred_taken=0; after two taken resolutions of ex_pc=0x10 -> next pc=0x80 and if_pred_taken=1.
REQ-023 Mispredict taken: ex_valid=1, ex_is_branch=1, ex_taken=1, ex_pred_taken=0, ex_target=0x200, stall=1 -> flush=1, next pc=0x200, if_valid=0, mispredict_cnt=1.
REQ-024 Mispredict not-taken: ex_pc=0x40, ex_taken=0, ex_pred_taken=1 -> next pc=0x44; counter saturates at 00 after three further not-taken updates.
REQ-025 Memory wait: imem_ready=0 for 3 cycles at pc=0x8 -> pc holds 0x8, if_valid=0, state WAIT; then imem_ready=1 -> if_pc=0x8, pc=0xC.
REQ-026 Reset mid-WAIT and counter wrap: assert rstn during WAIT -> pc=RESET_PC immediately; preload mispredict_cnt=32'hFFFF_FFFF, then one mispredict -> mispredict_cnt=0.
